// File: rtl/me_frame_sequencer.sv
// rtl/me_frame_sequencer.sv - per-frame macroblock sequencer for the full-search ME core
//
// Walks a frame in raster order, issues one me_req/me_ack transaction per
// macroblock, and queues each MB's {mb_x, mb_y, min_sad, min_mvec} into a
// small result FIFO that is read through a valid/ready port.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start                1-cycle frame start, honoured only in IDLE
//   busy                 high from accepted start through the frame_done cycle
//   frame_done           1-cycle pulse after the last MB result is pushed
//   mb_x, mb_y           current MB coordinates, stable while me_req is high
//   me_req / me_ack      request/acknowledge handshake with the ME core
//   min_sad, min_mvec    core result, valid while me_ack is high
//   res_valid/res_ready  result FIFO read handshake
//   res_mb_x, res_mb_y,
//   res_sad, res_mvec    FIFO head entry (zero while empty)

module me_frame_sequencer #(
  parameter int SAD_WIDTH  = 16,
  parameter int MVEC_WIDTH = 12,
  parameter int MB_COLS    = 8,
  parameter int MB_ROWS    = 6,
  parameter int FIFO_DEPTH = 4,
  localparam int XW        = $clog2(MB_COLS + 1),
  localparam int YW        = $clog2(MB_ROWS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  frame_done,
  output logic [XW-1:0]         mb_x,
  output logic [YW-1:0]         mb_y,
  output logic                  me_req,
  input  logic                  me_ack,
  input  logic [SAD_WIDTH-1:0]  min_sad,
  input  logic [MVEC_WIDTH-1:0] min_mvec,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [XW-1:0]         res_mb_x,
  output logic [YW-1:0]         res_mb_y,
  output logic [SAD_WIDTH-1:0]  res_sad,
  output logic [MVEC_WIDTH-1:0] res_mvec
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = XW + YW + SAD_WIDTH + MVEC_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic            me_req_nxt, busy_nxt, frame_done_nxt;
  logic [XW-1:0]   mb_x_nxt;
  logic [YW-1:0]   mb_y_nxt;

  logic [CW-1:0]   fifo_count;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [EW-1:0]   fifo_mem [FIFO_DEPTH];
  logic            push, pop, fifo_full;
  logic            last_col, last_mb;

  // Only REQ writes the FIFO, and CHECK only enters REQ with a free slot,
  // so push never lands on a full FIFO.
  assign push      = (state == S_REQ) && me_ack;
  assign res_valid = (fifo_count != '0);
  assign pop       = res_valid && res_ready;
  assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
  assign last_col  = (mb_x == XW'(MB_COLS - 1));
  assign last_mb   = last_col && (mb_y == YW'(MB_ROWS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      me_req     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      mb_x       <= '0;
      mb_y       <= '0;
    end else begin
      state      <= state_nxt;
      me_req     <= me_req_nxt;
      busy       <= busy_nxt;
      frame_done <= frame_done_nxt;
      mb_x       <= mb_x_nxt;
      mb_y       <= mb_y_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    me_req_nxt     = me_req;
    busy_nxt       = busy;
    frame_done_nxt = 1'b0;
    mb_x_nxt       = mb_x;
    mb_y_nxt       = mb_y;
    case (state)
      S_IDLE: begin
        if (start) begin
          mb_x_nxt  = '0;
          mb_y_nxt  = '0;
          busy_nxt  = 1'b1;
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!fifo_full) begin
          me_req_nxt = 1'b1;
          state_nxt  = S_REQ;
        end
      end
      S_REQ: begin
        if (me_ack) begin
          me_req_nxt = 1'b0;
          state_nxt  = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // Hold the coordinates until the core drops ack so the loaders
        // never see them change mid-handshake.
        if (!me_ack) begin
          if (last_mb) begin
            frame_done_nxt = 1'b1;
            state_nxt      = S_DONE;
          end else begin
            if (last_col) begin
              mb_x_nxt = '0;
              mb_y_nxt = mb_y + YW'(1);
            end else begin
              mb_x_nxt = mb_x + XW'(1);
            end
            state_nxt = S_CHECK;
          end
        end
      end
      S_DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: begin
        me_req_nxt = 1'b0;
        busy_nxt   = 1'b0;
        state_nxt  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO
  // is empty, so stale or uninitialised entries are never visible.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {mb_x, mb_y, min_sad, min_mvec};
  end

  assign {res_mb_x, res_mb_y, res_sad, res_mvec} = res_valid ? fifo_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_me_frame_sequencer.sv
// tb/tb_me_frame_sequencer.sv - directed self-checking bench for me_frame_sequencer

module tb_me_frame_sequencer;

  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, res_ready, model_en;
  logic        man_ack, auto_ack;
  logic [15:0] man_sad, auto_sad;
  logic [11:0] man_mvec, auto_mvec;
  logic        me_ack;
  logic [15:0] min_sad;
  logic [11:0] min_mvec;
  logic        busy, frame_done, me_req, res_valid;
  logic [3:0]  mb_x, res_mb_x;
  logic [2:0]  mb_y, res_mb_y;
  logic [15:0] res_sad;
  logic [11:0] res_mvec;

  assign me_ack   = model_en ? auto_ack  : man_ack;
  assign min_sad  = model_en ? auto_sad  : man_sad;
  assign min_mvec = model_en ? auto_mvec : man_mvec;

  logic        start1, ack1, ready1;
  logic [15:0] sad1;
  logic [11:0] mvec1;
  logic        busy1, frame_done1, me_req1, res_valid1;
  logic [0:0]  mb_x1, mb_y1, res_mb_x1, res_mb_y1;
  logic [15:0] res_sad1;
  logic [11:0] res_mvec1;

  me_frame_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .frame_done(frame_done),
    .mb_x(mb_x), .mb_y(mb_y), .me_req(me_req), .me_ack(me_ack),
    .min_sad(min_sad), .min_mvec(min_mvec), .res_valid(res_valid), .res_ready(res_ready),
    .res_mb_x(res_mb_x), .res_mb_y(res_mb_y), .res_sad(res_sad), .res_mvec(res_mvec)
  );

  me_frame_sequencer #(.MB_COLS(1), .MB_ROWS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .frame_done(frame_done1),
    .mb_x(mb_x1), .mb_y(mb_y1), .me_req(me_req1), .me_ack(ack1),
    .min_sad(sad1), .min_mvec(mvec1), .res_valid(res_valid1), .res_ready(ready1),
    .res_mb_x(res_mb_x1), .res_mb_y(res_mb_y1), .res_sad(res_sad1), .res_mvec(res_mvec1)
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_idx, fd_cnt, req_cnt, lat_cnt;
  logic prev_req;

  function automatic logic [15:0] sad_of(input int idx);
    return 16'(idx);
  endfunction

  function automatic logic [11:0] mvec_of(input int idx);
    return 12'(idx * 37);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Core model: ack LAT cycles after req, return sad = raster index.
  initial begin
    auto_ack = 1'b0; auto_sad = '0; auto_mvec = '0; lat_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || !model_en) begin
        auto_ack = 1'b0;
        lat_cnt  = 0;
      end else if (me_req && !auto_ack) begin
        if (lat_cnt >= LAT) begin
          auto_ack  = 1'b1;
          auto_sad  = sad_of(int'(mb_y) * 8 + int'(mb_x));
          auto_mvec = mvec_of(int'(mb_y) * 8 + int'(mb_x));
          lat_cnt   = 0;
        end else begin
          lat_cnt++;
        end
      end else if (!me_req && auto_ack) begin
        auto_ack = 1'b0;
      end
    end
  end

  // Consumer scoreboard: every pop must be the next MB in raster order.
  initial begin
    exp_idx = 0; fd_cnt = 0; req_cnt = 0; prev_req = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        exp_idx = 0; fd_cnt = 0; req_cnt = 0; prev_req = 1'b0;
      end else begin
        if (res_valid && res_ready) begin
          check("pop_mb_x", 32'(res_mb_x), 32'(exp_idx % 8));
          check("pop_mb_y", 32'(res_mb_y), 32'(exp_idx / 8));
          check("pop_sad",  32'(res_sad),  32'(sad_of(exp_idx)));
          check("pop_mvec", 32'(res_mvec), 32'(mvec_of(exp_idx)));
          exp_idx++;
        end
        if (frame_done) fd_cnt++;
        if (me_req && !prev_req) req_cnt++;
        prev_req = me_req;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!me_req && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", 32'(me_req), 32'd1);
  endtask

  task automatic do_mb(input int idx);
    wait_req();
    man_ack = 1'b1; man_sad = sad_of(idx); man_mvec = mvec_of(idx);
    @(negedge clk);
    man_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_fd(input int target, input int budget);
    int n = 0;
    while (fd_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_cnt", 32'(fd_cnt), 32'(target));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; res_ready = 1'b0; model_en = 1'b0;
    man_ack = 1'b0; man_sad = '0; man_mvec = '0;
    start1 = 1'b0; ack1 = 1'b0; sad1 = '0; mvec1 = '0; ready1 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_me_req", 32'(me_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_mb_xy", 32'({mb_x, mb_y}), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'({res_mb_x, res_mb_y, res_sad}), 32'd0);
    check("rst_res_mvec", 32'(res_mvec), 32'd0);
    check("rst_dut1_req", 32'(me_req1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-MB frame, core latency 10
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("t1_busy_rise", 32'(busy1), 32'd1);
    n = 0;
    while (!me_req1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t1_req", 32'(me_req1), 32'd1);
    repeat (10) @(negedge clk);
    ack1 = 1'b1; sad1 = 16'h0123; mvec1 = 12'h145;
    @(negedge clk);
    check("t1_req_drop", 32'(me_req1), 32'd0);
    check("t1_res_valid", 32'(res_valid1), 32'd1);
    check("t1_res_sad", 32'(res_sad1), 32'h0123);
    check("t1_res_mvec", 32'(res_mvec1), 32'h145);
    check("t1_res_xy", 32'({res_mb_x1, res_mb_y1}), 32'd0);
    check("t1_fd_early", 32'(frame_done1), 32'd0);
    ack1 = 1'b0;
    @(negedge clk);
    check("t1_frame_done", 32'(frame_done1), 32'd1);
    check("t1_busy_done", 32'(busy1), 32'd1);
    @(negedge clk);
    check("t1_fd_fall", 32'(frame_done1), 32'd0);
    check("t1_busy_fall", 32'(busy1), 32'd0);
    ready1 = 1'b1;
    @(negedge clk);
    ready1 = 1'b0;
    check("t1_drained", 32'(res_valid1), 32'd0);

    // Full frame with consumer always ready; start during DONE ignored
    res_ready = 1'b1;
    model_en  = 1'b1;
    pulse_start();
    n = 0;
    while (!frame_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("t2_fd_seen", 32'(frame_done), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t2_idle_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("t2_no_restart_busy", 32'(busy), 32'd0);
    check("t2_no_restart_req", 32'(me_req), 32'd0);
    check("t2_entries", 32'(exp_idx), 32'd48);
    check("t2_fd_once", 32'(fd_cnt), 32'd1);
    check("t2_empty", 32'(res_valid), 32'd0);

    // Back-pressure: four requests fill the FIFO, then the sequencer stalls
    do_reset();
    res_ready = 1'b0;
    pulse_start();
    repeat (150) @(negedge clk);
    check("t3_req_cnt4", 32'(req_cnt), 32'd4);
    check("t3_stall_req", 32'(me_req), 32'd0);
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_stall_mb", 32'({mb_y, mb_x}), 32'({3'd0, 4'd4}));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    repeat (60) @(negedge clk);
    check("t3_req_cnt5", 32'(req_cnt), 32'd5);
    check("t3_stall_req2", 32'(me_req), 32'd0);
    check("t3_stall_mb2", 32'({mb_y, mb_x}), 32'({3'd0, 4'd5}));
    check("t3_pops", 32'(exp_idx), 32'd1);

    // Manual core: start in REQ/RELEASE ignored, push+pop at count 2
    do_reset();
    check("t6_rst_discard", 32'(res_valid), 32'd0);
    model_en = 1'b0;
    pulse_start();
    wait_req();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_req_hold", 32'(me_req), 32'd1);
    check("t5_req_mb", 32'({mb_y, mb_x}), 32'd0);
    man_ack = 1'b1; man_sad = sad_of(0); man_mvec = mvec_of(0);
    @(negedge clk);
    check("t5_release_req", 32'(me_req), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    man_ack = 1'b0;
    check("t5_release_mb", 32'({mb_y, mb_x}), 32'd0);
    @(negedge clk);
    check("t5_advance_mb", 32'({mb_y, mb_x}), 32'd1);
    do_mb(1);
    wait_req();
    man_ack = 1'b1; man_sad = sad_of(2); man_mvec = mvec_of(2);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    man_ack = 1'b0;
    @(negedge clk);
    check("t4_head_sad", 32'(res_sad), 32'(sad_of(1)));
    check("t4_head_x", 32'(res_mb_x), 32'd1);
    do_mb(3);
    do_mb(4);
    repeat (20) @(negedge clk);
    check("t4_full_stall", 32'(me_req), 32'd0);
    check("t4_req_cnt", 32'(req_cnt), 32'd5);
    res_ready = 1'b1;
    repeat (4) @(negedge clk);
    res_ready = 1'b0;
    @(negedge clk);
    check("t4_drained", 32'(res_valid), 32'd0);
    check("t4_pops", 32'(exp_idx), 32'd5);
    check("t4_next_req", 32'(me_req), 32'd1);

    // Asynchronous reset while requesting MB (3,2), then a clean frame
    model_en  = 1'b1;
    res_ready = 1'b1;
    n = 0;
    while (!(me_req && mb_x == 4'd3 && mb_y == 3'd2) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t6_at_3_2", 32'({me_req, mb_y, mb_x}), 32'({1'b1, 3'd2, 4'd3}));
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_req", 32'(me_req), 32'd0);
    check("t6_async_busy", 32'(busy), 32'd0);
    check("t6_async_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    wait_fd(1, 3000);
    repeat (3) @(negedge clk);
    check("t6_entries", 32'(exp_idx), 32'd48);
    check("t6_busy_end", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
